// File: rtl/stream_fork_pkg.sv
// stream_fork_pkg
// Shared definitions for the stream fork controller.
//   NUM_OUT_DEF : default number of consumer streams
//   DATA_W_DEF  : default token width (16 data bits + 1 control bit)
//   CNT_W_DEF   : default width of the completed-token counter
//   state_t     : controller state encoding
package stream_fork_pkg;

    localparam int NUM_OUT_DEF = 7;
    localparam int DATA_W_DEF  = 17;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

endpackage

// File: rtl/fanout_ready_reduce.sv
// fanout_ready_reduce
// Combinational ready reduction for the fork.
// The producer may complete its handshake only when every consumer
// is either disabled, has already taken the token, or is taking it now.
// Ports:
//   act       in  NUM_OUT  consumers participating in the current token
//   sent_q    in  NUM_OUT  consumers that already took the current token
//   out_ready in  NUM_OUT  per-consumer ready
//   rdy       out 1        reduced producer-side ready term
module fanout_ready_reduce #(
    parameter int NUM_OUT = 7
) (
    input  logic [NUM_OUT-1:0] act,
    input  logic [NUM_OUT-1:0] sent_q,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic               rdy
);

    // A consumer blocks the producer only if it is enabled, has not
    // taken the token yet and is not ready in this cycle.
    assign rdy = &(~act | sent_q | out_ready);

endmodule

// File: rtl/stream_fork_ctrl.sv
// stream_fork_ctrl
// Eager fork: broadcasts one ready/valid stream to up to NUM_OUT consumers.
// Each enabled consumer takes the current token independently; the input
// handshake completes once all enabled consumers have taken it. Mask
// changes are applied only at token boundaries.
// Ports:
//   clk       in  1        clock
//   rst_n     in  1        synchronous active-low reset
//   cfg_load  in  1        load cfg_mask
//   cfg_mask  in  NUM_OUT  per-consumer enable mask
//   flush     in  1        synchronous soft clear (same effect as reset)
//   in_valid  in  1        producer token valid
//   in_data   in  DATA_W   producer token
//   in_ready  out 1        producer ready
//   out_valid out NUM_OUT  per-consumer valid
//   out_data  out DATA_W   broadcast token (wired from in_data)
//   out_ready in  NUM_OUT  per-consumer ready
//   cfg_busy  out 1        mask change pending
//   tok_cnt   out CNT_W    completed input handshakes, wrapping
module stream_fork_ctrl
    import stream_fork_pkg::*;
#(
    parameter int NUM_OUT = NUM_OUT_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_load,
    input  logic [NUM_OUT-1:0] cfg_mask,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic [NUM_OUT-1:0] out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic               cfg_busy,
    output logic [CNT_W-1:0]   tok_cnt
);

    state_t             state_q, state_d;
    logic [NUM_OUT-1:0] mask_q, mask_d;
    logic [NUM_OUT-1:0] pend_q, pend_d;
    logic [NUM_OUT-1:0] sent_q, sent_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_OUT-1:0] run_valid;
    logic [NUM_OUT-1:0] take;
    logic               rdy;
    logic               fire;

    assign out_data = in_data;
    assign tok_cnt  = cnt_q;

    fanout_ready_reduce #(
        .NUM_OUT (NUM_OUT)
    ) u_reduce (
        .act       (mask_q),
        .sent_q    (sent_q),
        .out_ready (out_ready),
        .rdy       (rdy)
    );

    // Per-consumer offer while a token is live; in_valid gates it so a
    // dropped valid mid-token holds sent_q without duplicate delivery.
    assign run_valid = {NUM_OUT{in_valid}} & mask_q & ~sent_q;
    assign take      = run_valid & out_ready;
    assign fire      = in_valid & rdy;

    // State, mask and progress registers; flush acts exactly like reset.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            state_q <= IDLE;
            mask_q  <= '0;
            pend_q  <= '0;
            sent_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            sent_q  <= sent_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output logic. A consumer that is ready on the fire
    // cycle is not recorded in sent_q because the token retires anyway.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        pend_d    = pend_q;
        sent_d    = sent_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = '0;
        cfg_busy  = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_load) begin
                    mask_d  = cfg_mask;
                    state_d = RUN;
                end
            end

            RUN: begin
                out_valid = run_valid;
                in_ready  = rdy;
                if (fire) begin
                    sent_d = '0;
                    cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    sent_d = sent_q | take;
                end
                if (cfg_load) begin
                    pend_d  = cfg_mask;
                    state_d = PEND;
                end
            end

            PEND: begin
                cfg_busy = 1'b1;
                if (sent_q == '0) begin
                    // At a token boundary: swap the mask without starting a token.
                    mask_d  = pend_q;
                    state_d = RUN;
                end else begin
                    // Finish the partially delivered token on the old mask.
                    out_valid = run_valid;
                    in_ready  = rdy;
                    if (fire) begin
                        sent_d  = '0;
                        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        mask_d  = pend_q;
                        state_d = RUN;
                    end else begin
                        sent_d = sent_q | take;
                    end
                end
                if (cfg_load) begin
                    pend_d = cfg_mask;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stream_fork_ctrl.sv
// tb_stream_fork_ctrl
// Directed bench for stream_fork_ctrl. Stimulus pushes the expected
// per-consumer takes and producer fires into queues; a monitor pops and
// compares them whenever the DUT shows a handshake. Per-cycle port values
// are also compared against hand-computed constants.
module tb_stream_fork_ctrl;

    localparam int NUM_OUT = 7;
    localparam int DATA_W  = 17;
    localparam int CNT_W   = 16;

    logic               clk;
    logic               rst_n;
    logic               cfg_load;
    logic [NUM_OUT-1:0] cfg_mask;
    logic               flush;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic               in_ready;
    logic [NUM_OUT-1:0] out_valid;
    logic [DATA_W-1:0]  out_data;
    logic [NUM_OUT-1:0] out_ready;
    logic               cfg_busy;
    logic [CNT_W-1:0]   tok_cnt;

    typedef struct {
        int                idx;
        logic [DATA_W-1:0] data;
    } take_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  cnt;
    } fire_t;

    take_t takeQ[$];
    fire_t fireQ[$];

    int checks   = 0;
    int failures = 0;

    logic             cntPending = 1'b0;
    logic [CNT_W-1:0] cntExpect  = '0;

    stream_fork_ctrl #(
        .NUM_OUT (NUM_OUT),
        .DATA_W  (DATA_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_load  (cfg_load),
        .cfg_mask  (cfg_mask),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .cfg_busy  (cfg_busy),
        .tok_cnt   (tok_cnt)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: timeout reached, required finish before it");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: at every falling edge, pop and compare each consumer take
    // and each producer fire; the counter after a fire is checked one
    // falling edge later.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cntPending) begin
                checks++;
                if (tok_cnt !== cntExpect) begin
                    failures++;
                    $display("[TB] FAIL fire_cnt: tok_cnt=%h required=%h", tok_cnt, cntExpect);
                end
                cntPending = 1'b0;
            end
            for (int i = 0; i < NUM_OUT; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    checks++;
                    if (takeQ.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL take_unexpected: consumer %0d took %h, required no take", i, out_data);
                    end else begin
                        take_t t;
                        t = takeQ.pop_front();
                        if (t.idx != i || out_data !== t.data) begin
                            failures++;
                            $display("[TB] FAIL take: consumer %0d data %h, required consumer %0d data %h",
                                     i, out_data, t.idx, t.data);
                        end
                    end
                end
            end
            if (in_valid && in_ready) begin
                checks++;
                if (fireQ.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL fire_unexpected: fire with data %h, required no fire", out_data);
                end else begin
                    fire_t f;
                    f = fireQ.pop_front();
                    if (out_data !== f.data) begin
                        failures++;
                        $display("[TB] FAIL fire_data: data %h required %h", out_data, f.data);
                    end
                    cntPending = 1'b1;
                    cntExpect  = f.cnt;
                end
            end
        end
    end

    task automatic applyStimulus(input logic ld, input logic [NUM_OUT-1:0] m, input logic fl,
                                 input logic v, input logic [DATA_W-1:0] d,
                                 input logic [NUM_OUT-1:0] r);
        cfg_load  = ld;
        cfg_mask  = m;
        flush     = fl;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic checkOutput(input string name, input logic er, input logic [NUM_OUT-1:0] ev,
                               input logic eb, input logic [CNT_W-1:0] ec);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, cfg_busy, tok_cnt} !== {er, ev, eb, ec}) begin
            failures++;
            $display("[TB] FAIL %s: in_ready=%b out_valid=%b cfg_busy=%b tok_cnt=%h required %b %b %b %h",
                     name, in_ready, out_valid, cfg_busy, tok_cnt, er, ev, eb, ec);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushTake(input int i, input logic [DATA_W-1:0] d);
        take_t t;
        t.idx  = i;
        t.data = d;
        takeQ.push_back(t);
    endtask

    task automatic pushFire(input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] c);
        fire_t f;
        f.data = d;
        f.cnt  = c;
        fireQ.push_back(f);
    endtask

    // Directed sequence.
    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 17'h0, 7'h00);
        step();
        step();
        checkOutput("reset", 1'b0, 7'b0000000, 1'b0, 16'h0000);
        step();
        rst_n = 1'b1;

        // Single token to consumers 0 and 2, all ready: same-cycle fire.
        applyStimulus(1'b1, 7'b0000101, 1'b0, 1'b0, 17'h0, 7'h00);
        checkOutput("idle_load", 1'b0, 7'b0000000, 1'b0, 16'h0000);
        step();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b1, 17'h1A5, 7'h7F);
        pushTake(0, 17'h1A5);
        pushTake(2, 17'h1A5);
        pushFire(17'h1A5, 16'h0001);
        checkOutput("t1_fire", 1'b1, 7'b0000101, 1'b0, 16'h0000);
        step();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 17'h1A5, 7'h7F);
        checkOutput("t1_after", 1'b1, 7'b0000000, 1'b0, 16'h0001);
        step();

        // Switch to mask 0000111 through PEND at a token boundary.
        applyStimulus(1'b1, 7'b0000111, 1'b0, 1'b0, 17'h0, 7'h00);
        checkOutput("t2_load", 1'b0, 7'b0000000, 1'b0, 16'h0001);
        step();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b1, 17'h0B2, 7'h00);
        checkOutput("t2_pend", 1'b0, 7'b0000000, 1'b1, 16'h0001);
        step();

        // Staggered takes: consumer 0, then 2, a stall, then 1 fires.
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b1, 17'h0B2, 7'b0000001);
        pushTake(0, 17'h0B2);
        checkOutput("t2_c0", 1'b0, 7'b0000111, 1'b0, 16'h0001);
        step();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b1, 17'h0B2, 7'b0000100);
        pushTake(2, 17'h0B2);
        checkOutput("t2_c1", 1'b0, 7'b0000110, 1'b0, 16'h0001);
        step();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b1, 17'h0B2, 7'b0000000);
        checkOutput("t2_c2", 1'b0, 7'b0000010, 1'b0, 16'h0001);
        step();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b1, 17'h0B2, 7'b0000010);
        pushTake(1, 17'h0B2);
        pushFire(17'h0B2, 16'h0002);
        checkOutput("t2_c3", 1'b1, 7'b0000010, 1'b0, 16'h0001);
        step();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 17'h0, 7'h00);
        checkOutput("t2_after", 1'b0, 7'b0000000, 1'b0, 16'h0002);
        step();

        // Mask change requested mid-token: old token finishes on old mask.
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b1, 17'h155, 7'b0000001);
        pushTake(0, 17'h155);
        checkOutput("t3_c0", 1'b0, 7'b0000111, 1'b0, 16'h0002);
        step();
        applyStimulus(1'b1, 7'b0000011, 1'b0, 1'b1, 17'h155, 7'b0000000);
        checkOutput("t3_load", 1'b0, 7'b0000110, 1'b0, 16'h0002);
        step();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b1, 17'h155, 7'b0000010);
        pushTake(1, 17'h155);
        checkOutput("t3_busy", 1'b0, 7'b0000110, 1'b1, 16'h0002);
        step();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b1, 17'h155, 7'b0000100);
        pushTake(2, 17'h155);
        pushFire(17'h155, 16'h0003);
        checkOutput("t3_fire", 1'b1, 7'b0000100, 1'b1, 16'h0002);
        step();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b1, 17'h0AA, 7'h7F);
        pushTake(0, 17'h0AA);
        pushTake(1, 17'h0AA);
        pushFire(17'h0AA, 16'h0004);
        checkOutput("t3_newmask", 1'b1, 7'b0000011, 1'b0, 16'h0003);
        step();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 17'h0, 7'h00);
        checkOutput("t3_after", 1'b0, 7'b0000000, 1'b0, 16'h0004);
        step();

        // Flush with consumer 1 already served; it must see the token again.
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b1, 17'h1F0, 7'b0000010);
        pushTake(1, 17'h1F0);
        checkOutput("t4_c0", 1'b0, 7'b0000011, 1'b0, 16'h0004);
        step();
        applyStimulus(1'b0, 7'h00, 1'b1, 1'b0, 17'h1F0, 7'h00);
        checkOutput("t4_flush", 1'b0, 7'b0000000, 1'b0, 16'h0004);
        step();
        applyStimulus(1'b1, 7'b0000011, 1'b0, 1'b1, 17'h1F0, 7'h7F);
        checkOutput("t4_idle", 1'b0, 7'b0000000, 1'b0, 16'h0000);
        step();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b1, 17'h1F0, 7'h7F);
        pushTake(0, 17'h1F0);
        pushTake(1, 17'h1F0);
        pushFire(17'h1F0, 16'h0001);
        checkOutput("t4_redeliver", 1'b1, 7'b0000011, 1'b0, 16'h0000);
        step();

        // Drop mode: empty mask consumes and counts tokens.
        applyStimulus(1'b0, 7'h00, 1'b1, 1'b0, 17'h0, 7'h00);
        checkOutput("t5_flush", 1'b0, 7'b0000000, 1'b0, 16'h0001);
        step();
        applyStimulus(1'b1, 7'b0000000, 1'b0, 1'b0, 17'h0, 7'h00);
        checkOutput("t5_load", 1'b0, 7'b0000000, 1'b0, 16'h0000);
        step();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 7'h00, 1'b0, 1'b1, 17'h100 + 17'(k), 7'h00);
            pushFire(17'h100 + 17'(k), 16'(k + 1));
            checkOutput("t5_drop", 1'b1, 7'b0000000, 1'b0, 16'(k));
            step();
        end
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 17'h0, 7'h00);
        checkOutput("t5_count", 1'b1, 7'b0000000, 1'b0, 16'h0005);
        step();

        // Run the counter up to 0xFFFF, then one more fire wraps it.
        for (int n = 5; n < 65535; n++) begin
            applyStimulus(1'b0, 7'h00, 1'b0, 1'b1, 17'(n), 7'h00);
            pushFire(17'(n), 16'(n + 1));
            step();
        end
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 17'h0, 7'h00);
        checkOutput("t6_max", 1'b1, 7'b0000000, 1'b0, 16'hFFFF);
        step();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b1, 17'h1234, 7'h00);
        pushFire(17'h1234, 16'h0000);
        checkOutput("t6_wrap_fire", 1'b1, 7'b0000000, 1'b0, 16'hFFFF);
        step();
        applyStimulus(1'b0, 7'h00, 1'b0, 1'b0, 17'h0, 7'h00);
        checkOutput("t6_wrapped", 1'b1, 7'b0000000, 1'b0, 16'h0000);
        step();

        // Every expected handshake must have been observed.
        checks++;
        if (takeQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL take_queue: %0d entries left, required 0", takeQ.size());
        end
        checks++;
        if (fireQ.size() != 0 || cntPending) begin
            failures++;
            $display("[TB] FAIL fire_queue: %0d entries left (cnt pending %b), required 0", fireQ.size(), cntPending);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
